// File: rtl/uart_cmd_parser.sv
// Byte-stream command decoder behind uart_rx: 'R' requests a board reset, '#RRGGBB' loads the LED colour.
// Define CMD_ACK_EN to queue a one-byte acknowledge ('K', 'E', 'R') on the tx_* handshake.
module uart_cmd_parser #(
   parameter int unsigned TIMEOUT_CYCLES = 1200000,
   parameter logic [7:0]  RST_CHAR       = 8'h52,
   parameter logic [7:0]  COLOR_CHAR     = 8'h23
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [7:0] rx_data,
   input  logic       rx_valid,
   output logic       rst_req,
   output logic [7:0] rgb_r,
   output logic [7:0] rgb_g,
   output logic [7:0] rgb_b,
   output logic       rgb_valid,
   output logic       err,
   output logic [7:0] tx_data,
   output logic       tx_valid,
   input  logic       tx_ready
);

   localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [CntW-1:0] CntMax = CntW'(TIMEOUT_CYCLES - 1);

   typedef enum logic [0:0] {StIdle, StHex} state_e;

   state_e          state_q, state_d;
   logic [CntW-1:0] cnt_q, cnt_d;
   logic [2:0]      digits_q, digits_d;
   // Only the first five digits need storing; the sixth goes straight to the outputs.
   logic [19:0]     shadow_q, shadow_d;

   logic            hex_ok;
   logic [3:0]      nib;
   logic            rst_req_d, rgb_valid_d, err_d;
   logic [23:0]     rgb_d;

   always_comb begin
      hex_ok = 1'b1;
      nib    = 4'h0;
      if (rx_data >= 8'h30 && rx_data <= 8'h39) begin
         nib = rx_data[3:0];
      end else if ((rx_data >= 8'h41 && rx_data <= 8'h46) ||
                   (rx_data >= 8'h61 && rx_data <= 8'h66)) begin
         nib = rx_data[3:0] + 4'd9;
      end else begin
         hex_ok = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= StIdle;
         cnt_q    <= '0;
         digits_q <= '0;
         shadow_q <= '0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         digits_q <= digits_d;
         shadow_q <= shadow_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      digits_d = digits_q;
      shadow_d = shadow_q;
      unique case (state_q)
         StIdle: begin
            cnt_d = '0;
            if (rx_valid && rx_data == COLOR_CHAR) begin
               state_d  = StHex;
               digits_d = '0;
               shadow_d = '0;
            end
         end
         StHex: begin
            if (rx_valid) begin
               cnt_d = '0;
               if (hex_ok) begin
                  shadow_d = {shadow_q[15:0], nib};
                  if (digits_q == 3'd5) begin
                     state_d  = StIdle;
                     digits_d = '0;
                  end else begin
                     digits_d = digits_q + 3'd1;
                  end
               end else if (rx_data == COLOR_CHAR) begin
                  digits_d = '0;
                  shadow_d = '0;
               end else begin
                  state_d  = StIdle;
                  digits_d = '0;
               end
            end else if (cnt_q == CntMax) begin
               state_d  = StIdle;
               cnt_d    = '0;
               digits_d = '0;
               shadow_d = '0;
            end else begin
               cnt_d = cnt_q + CntW'(1);
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_comb begin
      rst_req_d   = 1'b0;
      rgb_valid_d = 1'b0;
      err_d       = 1'b0;
      rgb_d       = {rgb_r, rgb_g, rgb_b};
      unique case (state_q)
         StIdle: rst_req_d = rx_valid && (rx_data == RST_CHAR);
         StHex: begin
            if (rx_valid) begin
               if (!hex_ok) begin
                  err_d = 1'b1;
               end else if (digits_q == 3'd5) begin
                  rgb_valid_d = 1'b1;
                  rgb_d       = {shadow_q, nib};
               end
            end else if (cnt_q == CntMax) begin
               err_d = 1'b1;
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rst_req   <= 1'b0;
         rgb_valid <= 1'b0;
         err       <= 1'b0;
         rgb_r     <= 8'h00;
         rgb_g     <= 8'h00;
         rgb_b     <= 8'h00;
      end else begin
         rst_req   <= rst_req_d;
         rgb_valid <= rgb_valid_d;
         err       <= err_d;
         rgb_r     <= rgb_d[23:16];
         rgb_g     <= rgb_d[15:8];
         rgb_b     <= rgb_d[7:0];
      end
   end

`ifdef CMD_ACK_EN
   logic       tx_valid_q;
   logic [7:0] tx_data_q;
   logic       ack_ev;
   logic [7:0] ack_code;

   assign ack_ev = rst_req | rgb_valid | err;

   always_comb begin
      ack_code = 8'h45;
      if (rgb_valid) begin
         ack_code = 8'h4B;
      end else if (rst_req) begin
         ack_code = 8'h52;
      end
   end

   // Single-entry buffer: an event is dropped unless the slot is empty or draining this cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tx_valid_q <= 1'b0;
         tx_data_q  <= 8'h00;
      end else if (ack_ev && (!tx_valid_q || tx_ready)) begin
         tx_valid_q <= 1'b1;
         tx_data_q  <= ack_code;
      end else if (tx_ready) begin
         tx_valid_q <= 1'b0;
      end
   end

   assign tx_valid = tx_valid_q;
   assign tx_data  = tx_data_q;
`else
   logic unused_tx_ready;
   assign unused_tx_ready = tx_ready;
   assign tx_valid        = 1'b0;
   assign tx_data         = 8'h00;
`endif

endmodule

// File: tb/tb_uart_cmd_parser.sv
// Self-checking bench for uart_cmd_parser: directed test-plan sequences followed by random byte
// streams, all compared cycle by cycle against a frame-level model.
module tb_uart_cmd_parser;

   localparam int unsigned T = 50;

   logic       clk;
   logic       rst_n;
   logic [7:0] rx_data;
   logic       rx_valid;
   logic       rst_req;
   logic [7:0] rgb_r, rgb_g, rgb_b;
   logic       rgb_valid;
   logic       err;
   logic [7:0] tx_data;
   logic       tx_valid;
   logic       tx_ready;

   uart_cmd_parser #(.TIMEOUT_CYCLES(T)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .rx_data   (rx_data),
      .rx_valid  (rx_valid),
      .rst_req   (rst_req),
      .rgb_r     (rgb_r),
      .rgb_g     (rgb_g),
      .rgb_b     (rgb_b),
      .rgb_valid (rgb_valid),
      .err       (err),
      .tx_data   (tx_data),
      .tx_valid  (tx_valid),
      .tx_ready  (tx_ready)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   // Reference model: frame contents as an accumulated integer plus a digit count.
   bit          m_frame;
   int          m_idle;
   int          m_ndig;
   int          m_val;
   logic [23:0] m_rgb;
   bit          e_rst, e_rgbv, e_err;
   bit          m_txv;
   logic [7:0]  m_txd;

   function automatic bit is_hex(input logic [7:0] c);
      return (c >= "0" && c <= "9") || (c >= "a" && c <= "f") || (c >= "A" && c <= "F");
   endfunction

   function automatic int hex_val(input logic [7:0] c);
      if (c >= "0" && c <= "9") return int'(c) - int'("0");
      if (c >= "a" && c <= "f") return int'(c) - int'("a") + 10;
      return int'(c) - int'("A") + 10;
   endfunction

   task automatic model_reset();
      m_frame = 0; m_idle = 0; m_ndig = 0; m_val = 0; m_rgb = '0;
      e_rst = 0; e_rgbv = 0; e_err = 0; m_txv = 0; m_txd = '0;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic check_outputs(input string tag);
      chk({tag, ".rst_req"},   32'(rst_req),   32'(e_rst));
      chk({tag, ".rgb_valid"}, 32'(rgb_valid), 32'(e_rgbv));
      chk({tag, ".err"},       32'(err),       32'(e_err));
      chk({tag, ".rgb"},       32'({rgb_r, rgb_g, rgb_b}), 32'(m_rgb));
      chk({tag, ".tx_valid"},  32'(tx_valid),  32'(m_txv));
      if (m_txv || tx_valid) chk({tag, ".tx_data"}, 32'(tx_data), 32'(m_txd));
   endtask

   // One clock: drive inputs, advance model, sample 1 ns after the edge.
   task automatic cycle(input bit v, input logic [7:0] d, input string tag);
`ifdef CMD_ACK_EN
      bit         evp;
      logic [7:0] code;
      evp  = e_rst | e_rgbv | e_err;
      code = e_rgbv ? 8'h4B : (e_rst ? 8'h52 : 8'h45);
`endif
      rx_valid = v;
      rx_data  = v ? d : 8'($urandom);
      tx_ready = 1'($urandom);
      e_rst = 0; e_rgbv = 0; e_err = 0;
      if (rst_n) begin
         if (v) begin
            if (!m_frame) begin
               if (d == 8'h52) e_rst = 1;
               else if (d == 8'h23) begin
                  m_frame = 1; m_ndig = 0; m_val = 0; m_idle = 0;
               end
            end else begin
               m_idle = 0;
               if (is_hex(d)) begin
                  m_val = m_val * 16 + hex_val(d);
                  m_ndig++;
                  if (m_ndig == 6) begin
                     m_rgb = 24'(m_val); e_rgbv = 1; m_frame = 0;
                  end
               end else begin
                  e_err = 1;
                  if (d == 8'h23) begin
                     m_ndig = 0; m_val = 0;
                  end else m_frame = 0;
               end
            end
         end else if (m_frame) begin
            m_idle++;
            if (m_idle == int'(T)) begin
               e_err = 1; m_frame = 0;
            end
         end
`ifdef CMD_ACK_EN
         if (m_txv && tx_ready) m_txv = 0;
         if (evp && !m_txv) begin
            m_txv = 1; m_txd = code;
         end
`endif
      end
      @(posedge clk);
      #1;
      check_outputs(tag);
   endtask

   task automatic idle(input int n, input string tag);
      for (int i = 0; i < n; i++) cycle(0, 8'h00, tag);
   endtask

   task automatic send_str(input string s, input int gap, input string tag);
      for (int i = 0; i < s.len(); i++) begin
         cycle(1, s[i], tag);
         idle(gap, tag);
      end
   endtask

   initial begin
      string       hx;
      logic [7:0]  b;
      int          r;
      hx       = "0123456789abcdefABCDEF";
      rst_n    = 1'b0;
      rx_valid = 1'b0;
      rx_data  = 8'h00;
      tx_ready = 1'b0;
      model_reset();
      #1;
      check_outputs("reset");
      #12;
      rst_n = 1'b1;

      send_str("R", 0, "rst_cmd");
      idle(3, "rst_cmd");

      send_str("#12aBfF", 0, "color");
      idle(4, "color");

      send_str("#12G", 1, "bad_hex");
      send_str("R", 0, "bad_hex_r");
      idle(2, "bad_hex_r");

      send_str("#12", 0, "timeout");
      idle(int'(T) + 2, "timeout");
      send_str("345678", 0, "after_to");
      idle(3, "after_to");

      send_str("#12#00FF00", 0, "restart");
      idle(3, "restart");

      send_str("#123", 0, "midrst");
      rst_n = 1'b0;
      #1;
      model_reset();
      check_outputs("midrst_async");
      idle(2, "midrst_hold");
      #2;
      rst_n = 1'b1;
      send_str("#010203", 0, "post_rst");
      idle(3, "post_rst");

      for (int i = 0; i < 400; i++) begin
         r = int'($urandom_range(0, 11));
         if (r < 7)       b = hx[int'($urandom_range(0, hx.len() - 1))];
         else if (r < 9)  b = 8'h23;
         else if (r == 9) b = 8'h52;
         else             b = 8'($urandom);
         cycle(1, b, "rand");
         if ($urandom_range(0, 24) == 0) idle(int'($urandom_range(T - 3, T + 3)), "rand_gap");
         else idle(int'($urandom_range(0, 2)), "rand_gap");
      end
      idle(4, "drain");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
